// File: rtl/dpram_sweep.sv
// Single-clock true dual-port RAM with a clear sweeper, read-valid strobes and collision/range checks.
// Define DPRAM_SWEEP_OUTREG_EN to add an output pipeline stage (read latency 2 instead of 1).
module dpram_sweep #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 12,
    parameter int                 DEPTH   = 4096,
    parameter int                 RD_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr_req,
    output logic              Ready,
    input  logic              Ena,
    input  logic              Wea,
    input  logic [ADDR_W-1:0] Addra,
    input  logic [DATA_W-1:0] Dina,
    output logic [DATA_W-1:0] Douta,
    output logic              Valida,
    input  logic              Enb,
    input  logic              Web,
    input  logic [ADDR_W-1:0] Addrb,
    input  logic [DATA_W-1:0] Dinb,
    output logic [DATA_W-1:0] Doutb,
    output logic              Validb,
    output logic              Collision,
    output logic              Addr_err
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // One extra counter bit so DEPTH == 2**ADDR_W is reachable without wrapping.
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0] douta_q, douta_d, doutb_q, doutb_d;
    logic              valida_q, valida_d, validb_q, validb_d;
    logic              coll_q, coll_d, aerr_q, aerr_d;

    logic              run, in_a, in_b, acc_a, acc_b, same_addr;
    logic              we_a, we_b, coll;
    logic [DATA_W-1:0] old_a, old_b, rd_a, rd_b;

    assign run       = (state_q == ST_RUN);
    assign in_a      = ({1'b0, Addra} < DEPTH_W);
    assign in_b      = ({1'b0, Addrb} < DEPTH_W);
    assign acc_a     = run && Ena && in_a;
    assign acc_b     = run && Enb && in_b;
    assign same_addr = (Addra == Addrb);
    // On a same-address double write port A wins, so port B's write is dropped.
    assign coll      = acc_a && Wea && acc_b && Web && same_addr;
    assign we_a      = acc_a && Wea;
    assign we_b      = acc_b && Web && !coll;
    assign old_a     = mem[Addra];
    assign old_b     = mem[Addrb];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (Clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_a = old_a;
        rd_b = old_b;
        if (RD_MODE != 0) begin
            if (we_a)                   rd_a = Dina;
            else if (we_b && same_addr) rd_a = Dinb;
            if (we_b)                   rd_b = Dinb;
            else if (we_a && same_addr) rd_b = Dina;
        end
    end

    always_comb begin
        douta_d  = acc_a ? rd_a : douta_q;
        doutb_d  = acc_b ? rd_b : doutb_q;
        valida_d = acc_a;
        validb_d = acc_b;
        coll_d   = coll;
        aerr_d   = run && ((Ena && !in_a) || (Enb && !in_b));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            douta_q  <= '0;
            doutb_q  <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
            coll_q   <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            douta_q  <= douta_d;
            doutb_q  <= doutb_d;
            valida_q <= valida_d;
            validb_q <= validb_d;
            coll_q   <= coll_d;
            aerr_q   <= aerr_d;
        end
    end

    // NOTE: the array has no reset; the clear sweep initialises it so it can map onto block RAM.
    always_ff @(posedge Clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q[ADDR_W-1:0]] <= CLR_VAL;
        end else begin
            if (we_a) mem[Addra] <= Dina;
            if (we_b) mem[Addrb] <= Dinb;
        end
    end

    assign Ready = run;

`ifdef DPRAM_SWEEP_OUTREG_EN
    logic [DATA_W-1:0] douta_p_q, doutb_p_q;
    logic              valida_p_q, validb_p_q, coll_p_q, aerr_p_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            douta_p_q  <= '0;
            doutb_p_q  <= '0;
            valida_p_q <= 1'b0;
            validb_p_q <= 1'b0;
            coll_p_q   <= 1'b0;
            aerr_p_q   <= 1'b0;
        end else begin
            douta_p_q  <= douta_q;
            doutb_p_q  <= doutb_q;
            valida_p_q <= valida_q;
            validb_p_q <= validb_q;
            coll_p_q   <= coll_q;
            aerr_p_q   <= aerr_q;
        end
    end

    assign Douta     = douta_p_q;
    assign Doutb     = doutb_p_q;
    assign Valida    = valida_p_q;
    assign Validb    = validb_p_q;
    assign Collision = coll_p_q;
    assign Addr_err  = aerr_p_q;
`else
    assign Douta     = douta_q;
    assign Doutb     = doutb_q;
    assign Valida    = valida_q;
    assign Validb    = validb_q;
    assign Collision = coll_q;
    assign Addr_err  = aerr_q;
`endif

endmodule

// File: tb/tb_dpram_sweep.sv
// Directed bench for dpram_sweep: a 16-word read-first and a 12-word write-first instance
// share one stimulus stream; expected values come from hand-computed constants and a word model.
module tb_dpram_sweep;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Clr_req = 1'b0;
    logic        Ena = 1'b0, Wea = 1'b0, Enb = 1'b0, Web = 1'b0;
    logic [3:0]  Addra = '0, Addrb = '0;
    logic [31:0] Dina = '0, Dinb = '0;

    logic        r16, va16, vb16, co16, ae16;
    logic [31:0] da16, db16;
    logic        r12, va12, vb12, co12, ae12;
    logic [31:0] da12, db12;

    logic [31:0] exp16 [16];
    logic [31:0] exp12 [16];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dpram_sweep #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .CLR_VAL(CV)) u_dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .Clr_req(Clr_req), .Ready(r16),
        .Ena(Ena), .Wea(Wea), .Addra(Addra), .Dina(Dina), .Douta(da16), .Valida(va16),
        .Enb(Enb), .Web(Web), .Addrb(Addrb), .Dinb(Dinb), .Doutb(db16), .Validb(vb16),
        .Collision(co16), .Addr_err(ae16)
    );

    dpram_sweep #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .CLR_VAL(CV)) u_dut12 (
        .Clk(Clk), .Rst_n(Rst_n), .Clr_req(Clr_req), .Ready(r12),
        .Ena(Ena), .Wea(Wea), .Addra(Addra), .Dina(Dina), .Douta(da12), .Valida(va12),
        .Enb(Enb), .Web(Web), .Addrb(Addrb), .Dinb(Dinb), .Doutb(db12), .Validb(vb12),
        .Collision(co12), .Addr_err(ae12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Ena = 1'b0; Wea = 1'b0; Enb = 1'b0; Web = 1'b0; Clr_req = 1'b0;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            exp16[i] = CV;
            exp12[i] = CV;
        end
    endtask

    task automatic wait_ready(output int n16, output int n12);
        n16 = 0;
        n12 = 0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            if (r16 && n16 == 0) n16 = k;
            if (r12 && n12 == 0) n12 = k;
        end
    endtask

    // Both ports read the same address every cycle; the 12-word instance flags 12..15.
    task automatic read_all(input string tag);
        logic [31:0] hold12;
        hold12 = da12;
        for (int i = 0; i < 16; i++) begin
            Ena = 1'b1; Wea = 1'b0; Addra = 4'(i);
            Enb = 1'b1; Web = 1'b0; Addrb = 4'(i);
            cycle();
            check($sformatf("%s_a16_%0d", tag, i), da16, exp16[i]);
            check($sformatf("%s_va16_%0d", tag, i), {31'd0, va16}, 32'd1);
            check($sformatf("%s_b16_%0d", tag, i), db16, exp16[i]);
            if (i < 12) begin
                check($sformatf("%s_a12_%0d", tag, i), da12, exp12[i]);
                check($sformatf("%s_vb12_%0d", tag, i), {31'd0, vb12}, 32'd1);
                hold12 = exp12[i];
            end else begin
                check($sformatf("%s_hold12_%0d", tag, i), da12, hold12);
                check($sformatf("%s_va12_%0d", tag, i), {31'd0, va12}, 32'd0);
                check($sformatf("%s_aerr12_%0d", tag, i), {31'd0, ae12}, 32'd1);
            end
        end
        idle();
    endtask

    initial begin
        int n16, n12, bad;
        idle();
        repeat (2) cycle();
        check("rst_ready16", {31'd0, r16}, 32'd0);
        check("rst_ready12", {31'd0, r12}, 32'd0);
        check("rst_douta16", da16, 32'd0);
        check("rst_flags16", {28'd0, va16, vb16, co16, ae16}, 32'd0);

        // Sweep after release; port traffic during CLEAR must be ignored.
        Rst_n = 1'b1;
        n16 = 0; n12 = 0; bad = 0;
        for (int k = 1; k <= 24; k++) begin
            Ena = (k <= 10); Wea = Ena; Addra = 4'd2; Dina = 32'hDEADBEEF;
            Enb = (k <= 10); Web = 1'b0; Addrb = 4'd14;
            cycle();
            if (k <= 11 && (va16 || vb16 || va12 || vb12 || ae12 || co16)) bad++;
            if (r16 && n16 == 0) n16 = k;
            if (r12 && n12 == 0) n12 = k;
        end
        idle();
        check("sweep_ignored", bad, 0);
        check("sweep_ready16", n16, 16);
        check("sweep_ready12", n12, 12);
        clear_models();
        read_all("clr");

        cycle();
        check("idle_va16", {31'd0, va16}, 32'd0);
        check("idle_hold16", da16, CV);

        // Basic write on A, then read on B.
        Ena = 1'b1; Wea = 1'b1; Addra = 4'd5; Dina = 32'h12345678;
        cycle();
        check("wr_old16", da16, CV);
        check("wr_new12", da12, 32'h12345678);
        check("wr_va12", {31'd0, va12}, 32'd1);
        exp16[5] = 32'h12345678; exp12[5] = 32'h12345678;
        idle();
        Enb = 1'b1; Addrb = 4'd5;
        cycle();
        check("rd_b16", db16, 32'h12345678);
        check("rd_b12", db12, 32'h12345678);
        check("rd_vb16", {31'd0, vb16}, 32'd1);

        // A writes while B reads the same word.
        Ena = 1'b1; Wea = 1'b1; Addra = 4'd9; Dina = 32'hCAFE0009;
        Enb = 1'b1; Web = 1'b0; Addrb = 4'd9;
        cycle();
        check("rdw_b16", db16, CV);
        check("rdw_b12", db12, 32'hCAFE0009);
        exp16[9] = 32'hCAFE0009; exp12[9] = 32'hCAFE0009;

        // Same-address double write: port A data wins.
        Ena = 1'b1; Wea = 1'b1; Addra = 4'd7; Dina = 32'h1111;
        Enb = 1'b1; Web = 1'b1; Addrb = 4'd7; Dinb = 32'h2222;
        cycle();
        check("coll16", {31'd0, co16}, 32'd1);
        check("coll12", {31'd0, co12}, 32'd1);
        check("coll_a16", da16, CV);
        check("coll_b16", db16, CV);
        check("coll_a12", da12, 32'h1111);
        check("coll_b12", db12, 32'h1111);
        exp16[7] = 32'h1111; exp12[7] = 32'h1111;
        Wea = 1'b0; Web = 1'b0;
        cycle();
        check("coll_clear16", {31'd0, co16}, 32'd0);
        check("coll_rd16", da16, 32'h1111);
        check("coll_rd12", db12, 32'h1111);
        idle();

        // Write enable without port enable does nothing.
        Wea = 1'b1; Addra = 4'd4; Dina = 32'h77;
        cycle();
        check("noen_va16", {31'd0, va16}, 32'd0);
        idle();

        // Address 13 is out of range only for the 12-word instance.
        Ena = 1'b1; Wea = 1'b1; Addra = 4'd13; Dina = 32'hDEAD;
        cycle();
        check("oor_aerr12", {31'd0, ae12}, 32'd1);
        check("oor_va12", {31'd0, va12}, 32'd0);
        check("oor_hold12", da12, 32'h1111);
        check("oor_aerr16", {31'd0, ae16}, 32'd0);
        check("oor_a16", da16, CV);
        exp16[13] = 32'hDEAD;
        idle();
        cycle();
        check("oor_pulse12", {31'd0, ae12}, 32'd0);
        read_all("oor");

        // Clear request together with a write: the write still executes.
        Clr_req = 1'b1; Ena = 1'b1; Wea = 1'b1; Addra = 4'd3; Dina = 32'hBEEF;
        cycle();
        check("rclr_ready16", {31'd0, r16}, 32'd0);
        check("rclr_ready12", {31'd0, r12}, 32'd0);
        check("rclr_a16", da16, CV);
        check("rclr_a12", da12, 32'hBEEF);
        idle();
        wait_ready(n16, n12);
        check("rclr_time16", n16, 16);
        check("rclr_time12", n12, 12);
        clear_models();
        read_all("rclr");

        // Dirty a few words, start a sweep, reset at count 6.
        Ena = 1'b1; Wea = 1'b1; Addra = 4'd10; Dina = 32'h10101010;
        Enb = 1'b1; Web = 1'b1; Addrb = 4'd15; Dinb = 32'h15151515;
        cycle();
        idle();
        Clr_req = 1'b1;
        cycle();
        idle();
        repeat (6) cycle();
        Rst_n = 1'b0;
        #1;
        check("mrst_ready16", {31'd0, r16}, 32'd0);
        check("mrst_a16", da16, 32'd0);
        check("mrst_b12", db12, 32'd0);
        check("mrst_flags12", {28'd0, va12, vb12, co12, ae12}, 32'd0);
        repeat (2) cycle();
        Rst_n = 1'b1;
        wait_ready(n16, n12);
        check("mrst_time16", n16, 16);
        check("mrst_time12", n12, 12);
        clear_models();
        read_all("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_sweep.md
Name: dpram_sweep

Overview:
- Parametrised single-clock true dual-port RAM for ECG sample and feature storage.
- Generalises the fixed 4096x32 block-RAM wrapper to any width and depth.
- Adds a post-reset/on-demand clear sweeper, read-valid strobes, deterministic same-address collision handling and out-of-range address protection.
- Sits between the ECG acquisition writer (port A) and the processing/readout engine (port B).

Parameters:
- DATA_W, 32, data width of both ports in bits.
- ADDR_W, 12, address width of both ports.
- DEPTH, 4096, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- RD_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
- Clk  in  1  single clock, all logic rising-edge.
- Rst_n  in  1  asynchronous active-low reset.
- Clr_req  in  1  single-cycle request to re-clear the whole memory.
- Ready  out  1  high when the sweep is done and ports are accepted.
- Ena  in  1  port A enable.
- Wea  in  1  port A write enable (qualified by Ena).
- Addra  in  ADDR_W  port A address.
- Dina  in  DATA_W  port A write data.
- Douta  out  DATA_W  port A read data.
- Valida  out  1  port A read-data strobe.
- Enb, Web, Addrb, Dinb, Doutb, Validb: port B, identical to port A.
- Collision  out  1  pulse: both ports wrote the same address in one cycle.
- Addr_err  out  1  pulse: an enabled access on either port used an address >= DEPTH.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Douta, Doutb, Valida, Validb, Collision, Addr_err, Ready all go to 0.
  - The FSM enters CLEAR with the sweep counter at 0.
  - Memory array contents are not reset.
- FSM states: CLEAR and RUN.
  - CLEAR: writes CLR_VAL to address cnt each cycle, cnt = 0..DEPTH-1. Ready = 0. Port enables are ignored: no writes, Valid stays 0, no Collision/Addr_err. Clr_req is ignored.
  - CLEAR -> RUN in the cycle after address DEPTH-1 is written. The sweep takes exactly DEPTH cycles after reset release. Ready rises on the first RUN cycle.
  - RUN: Clr_req = 1 returns the FSM to CLEAR with cnt = 0 and Ready = 0 on the next cycle. The port access presented in the same cycle as Clr_req is still executed.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release.
- Read latency (RUN): an access with EnX = 1 and an in-range address produces DoutX and ValidX = 1 one cycle later. ValidX pulses for both reads and writes.
- DoutX holds its last value whenever ValidX = 0.
- Write on port X: the returned DoutX follows RD_MODE.
  - RD_MODE = 0: returns the old word.
  - RD_MODE = 1: returns Din.
- Port A writes and port B reads the same address in the same cycle: Doutb follows RD_MODE. The symmetric case (B writes, A reads) behaves the same way.
- Both ports write the same address in the same cycle:
  - Port A data is stored.
  - Collision = 1 for one cycle, aligned with the Valid strobes.
  - Both Dout values follow RD_MODE relative to the stored (port A) data.
- Both ports read the same address: no conflict, both return the word.
- Out-of-range address (>= DEPTH):
  - The write is suppressed.
  - Valid stays 0 and Dout holds.
  - Addr_err pulses one cycle later. Addr_err is the OR over both ports.
- Wea or Web with the matching enable low: no effect.
- Sweep counter width is ADDR_W+1 so that DEPTH = 2**ADDR_W terminates without wrap.

Optional Feature:
- Macro: DPRAM_SWEEP_OUTREG_EN.
- Defined:
  - An extra output pipeline register is added on DoutX, ValidX, Collision and Addr_err.
  - Read latency becomes 2 cycles and all strobes stay aligned with their data.
  - Reset value of the added registers is 0.
- Undefined: latency is 1 cycle as specified above.

Test Plan:
- Reset/clear: DEPTH = 16, CLR_VAL = 32'hA5A5A5A5, preload garbage via back-door, release Rst_n.
  - Required: Ready rises exactly 16 cycles later.
  - Required: reads of addresses 0..15 return A5A5A5A5 with Valida one cycle after Ena.
- Basic R/W: write 32'h12345678 at A address 5, then read at B address 5.
  - Required: Doutb = 12345678 with Validb one cycle after the read.
  - Required: Douta on the write cycle = old word (RD_MODE = 0) or 12345678 (RD_MODE = 1).
- Collision: A writes 32'h1111 and B writes 32'h2222, both to address 7, same cycle.
  - Required: Collision pulses one cycle later.
  - Required: a subsequent read of address 7 returns 1111.
- Out-of-range: DEPTH = 12, write 32'hDEAD at address 13.
  - Required: Addr_err pulses, Valida = 0, Douta unchanged.
  - Required: addresses 0..11 are unchanged.
- Re-clear: in RUN, pulse Clr_req together with a write of 32'hBEEF at address 3.
  - Required: Ready falls next cycle and stays low for DEPTH cycles.
  - Required: address 3 afterwards reads CLR_VAL.
- Reset mid-sweep: assert Rst_n low at sweep count 6, release.
  - Required: outputs are 0 during reset.
  - Required: Ready rises DEPTH cycles after release and all words equal CLR_VAL.
